motor_move_ctrl: RTL and testbench

Closed-loop move sequencer that sits above the quadrature decoder and motor driver. It accepts one relative-free, absolute-position move command at a time and drives the motor enable, direction and PWM duty. It ramps the duty up, slows down near the target, and brakes when the target is reached. It tracks position from decoder step/direction pulses and faults if the encoder stops moving while the motor is driven.

---
 rtl/motor_ctrl_pkg.sv | 25 ++
 rtl/enc_pos_counter.sv | 29 ++
 rtl/motor_move_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_motor_move_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_ctrl_pkg.sv
// Shared types and default constants for the motor move sequencer.
package motor_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RAMP,
    RUN,
    BRAKE,
    DONE,
    FAULT
  } state_t;

  localparam logic [1:0] ST_REACHED = 2'd0;
  localparam logic [1:0] ST_ABORT   = 2'd1;
  localparam logic [1:0] ST_STALL   = 2'd2;

  localparam int DEF_POS_W        = 24;
  localparam int DEF_DUTY_W       = 8;
  localparam int DEF_RAMP_DIV     = 256;
  localparam int DEF_SLOW_ZONE    = 64;
  localparam int DEF_SLOW_DUTY    = 40;
  localparam int DEF_BRAKE_CYCLES = 1000;
  localparam int DEF_STALL_CYCLES = 100000;

endpackage

// File: rtl/enc_pos_counter.sv
// Signed position accumulator fed by decoded encoder step/direction pulses.
module enc_pos_counter
  import motor_ctrl_pkg::*;
#(
  parameter int POS_W = DEF_POS_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enc_step,
  input  logic             enc_dir,
  input  logic             clear,
  output logic [POS_W-1:0] position,
  output logic             stall_clr
);

  // Clear has priority over a coincident step; wrap is natural modulo 2^POS_W.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      position <= '0;
    end else if (clear) begin
      position <= '0;
    end else if (enc_step) begin
      position <= enc_dir ? position + POS_W'(1) : position - POS_W'(1);
    end
  end

  assign stall_clr = enc_step;

endmodule

// File: rtl/motor_move_ctrl.sv
// Closed-loop move sequencer: ramps duty, slows near target, brakes, and
// faults when the encoder stops moving while the motor is driven.
module motor_move_ctrl
  import motor_ctrl_pkg::*;
#(
  parameter int POS_W        = DEF_POS_W,
  parameter int DUTY_W       = DEF_DUTY_W,
  parameter int RAMP_DIV     = DEF_RAMP_DIV,
  parameter int SLOW_ZONE    = DEF_SLOW_ZONE,
  parameter int SLOW_DUTY    = DEF_SLOW_DUTY,
  parameter int BRAKE_CYCLES = DEF_BRAKE_CYCLES,
  parameter int STALL_CYCLES = DEF_STALL_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enc_step,
  input  logic              enc_dir,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [POS_W-1:0]  cmd_target,
  input  logic [DUTY_W-1:0] cmd_speed,
  input  logic              abort,
  input  logic              pos_clear,
  input  logic              fault_clr,
  output logic              motor_en,
  output logic              motor_dir,
  output logic [DUTY_W-1:0] pwm_duty,
  output logic [POS_W-1:0]  position,
  output logic              busy,
  output logic              done,
  output logic [1:0]        status,
  output logic              fault
);

  localparam int RAMP_W  = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int BRAKE_W = (BRAKE_CYCLES > 1) ? $clog2(BRAKE_CYCLES) : 1;
  localparam int STALL_W = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;
  localparam logic [POS_W-1:0]  POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
  localparam logic [POS_W-1:0]  POS_MIN = {1'b1, {(POS_W-1){1'b0}}};
  localparam logic [DUTY_W-1:0] SLOW_D  = DUTY_W'(SLOW_DUTY);

  state_t              state_q, state_d;
  logic [POS_W-1:0]    target_q, target_d;
  logic [DUTY_W-1:0]   speed_q, speed_d;
  logic [DUTY_W-1:0]   duty_q, duty_d;
  logic                dir_q, dir_d;
  logic [1:0]          status_q, status_d;
  logic [RAMP_W-1:0]   ramp_cnt_q, ramp_cnt_d;
  logic [BRAKE_W-1:0]  brake_cnt_q, brake_cnt_d;
  logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic                stall_clr;
  logic [POS_W-1:0]    remaining, accept_rem, rem_abs;
  logic                in_slow, reached, stall_hit;
  logic [DUTY_W-1:0]   limit;

  enc_pos_counter #(.POS_W(POS_W)) u_pos (
    .clk       (clk),
    .rst       (rst),
    .enc_step  (enc_step),
    .enc_dir   (enc_dir),
    .clear     (pos_clear && (state_q == IDLE)),
    .position  (position),
    .stall_clr (stall_clr)
  );

  assign remaining  = target_q - position;
  assign accept_rem = cmd_target - position;

  always_comb begin
    if (!remaining[POS_W-1])       rem_abs = remaining;
    else if (remaining == POS_MIN) rem_abs = POS_MAX;
    else                           rem_abs = '0 - remaining;
  end

  assign in_slow   = (rem_abs <= POS_W'(SLOW_ZONE));
  assign limit     = (in_slow && (speed_q > SLOW_D)) ? SLOW_D : speed_q;
  // Overshoot shows up as remaining having the sign opposite to the drive direction.
  assign reached   = (remaining == '0) || (remaining[POS_W-1] == dir_q);
  assign stall_hit = (stall_cnt_q == STALL_W'(STALL_CYCLES - 1)) && !stall_clr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      target_q    <= '0;
      speed_q     <= '0;
      duty_q      <= '0;
      dir_q       <= 1'b0;
      status_q    <= ST_REACHED;
      ramp_cnt_q  <= '0;
      brake_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      speed_q     <= speed_d;
      duty_q      <= duty_d;
      dir_q       <= dir_d;
      status_q    <= status_d;
      ramp_cnt_q  <= ramp_cnt_d;
      brake_cnt_q <= brake_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    speed_d     = speed_q;
    duty_d      = duty_q;
    dir_d       = dir_q;
    status_d    = status_q;
    ramp_cnt_d  = ramp_cnt_q;
    brake_cnt_d = brake_cnt_q;
    stall_cnt_d = stall_cnt_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          target_d = cmd_target;
          speed_d  = cmd_speed;
          status_d = ST_REACHED;
          duty_d   = '0;
          if (accept_rem == '0) begin
            state_d = DONE;
          end else begin
            dir_d       = ~accept_rem[POS_W-1];
            ramp_cnt_d  = '0;
            stall_cnt_d = '0;
            state_d     = RAMP;
          end
        end
      end
      RAMP, RUN: begin
        stall_cnt_d = stall_clr ? '0 : stall_cnt_q + STALL_W'(1);
        if (reached) begin
          state_d     = BRAKE;
          status_d    = ST_REACHED;
          duty_d      = '0;
          brake_cnt_d = '0;
        end else if (stall_hit) begin
          state_d  = FAULT;
          status_d = ST_STALL;
          duty_d   = '0;
        end else if (abort) begin
          state_d     = BRAKE;
          status_d    = ST_ABORT;
          duty_d      = '0;
          brake_cnt_d = '0;
        end else if (state_q == RUN) begin
          duty_d = limit;
        end else if (duty_q >= limit) begin
          duty_d  = limit;
          state_d = RUN;
        end else if (ramp_cnt_q == RAMP_W'(RAMP_DIV - 1)) begin
          duty_d     = duty_q + DUTY_W'(1);
          ramp_cnt_d = '0;
        end else begin
          ramp_cnt_d = ramp_cnt_q + RAMP_W'(1);
        end
      end
      BRAKE: begin
        if (brake_cnt_q == BRAKE_W'(BRAKE_CYCLES - 1)) state_d = DONE;
        else brake_cnt_d = brake_cnt_q + BRAKE_W'(1);
      end
      DONE: begin
        state_d = IDLE;
      end
      FAULT: begin
        if (fault_clr) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign fault     = (state_q == FAULT);
  assign motor_en  = (state_q == RAMP) || (state_q == RUN);
  assign motor_dir = dir_q;
  assign pwm_duty  = duty_q;
  assign status    = status_q;

endmodule

// File: tb/tb_motor_move_ctrl.sv
// Scoreboard bench for motor_move_ctrl: random and directed moves against a
// behavioural encoder/plant and move-outcome model.
module tb_motor_move_ctrl;
  import motor_ctrl_pkg::*;

  localparam int POS_W        = 24;
  localparam int DUTY_W       = 8;
  localparam int RAMP_DIV     = 4;
  localparam int SLOW_ZONE    = 64;
  localparam int SLOW_DUTY    = 40;
  localparam int BRAKE_CYCLES = 1000;
  localparam int STALL_CYCLES = 50;
  localparam int STEP_PERIOD  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              enc_step = 1'b0;
  logic              enc_dir = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [POS_W-1:0]  cmd_target = '0;
  logic [DUTY_W-1:0] cmd_speed = '0;
  logic              abort = 1'b0;
  logic              pos_clear = 1'b0;
  logic              fault_clr = 1'b0;
  logic              motor_en, motor_dir, busy, done, fault;
  logic [DUTY_W-1:0] pwm_duty;
  logic [POS_W-1:0]  position;
  logic [1:0]        status;

  motor_move_ctrl #(
    .POS_W(POS_W), .DUTY_W(DUTY_W), .RAMP_DIV(RAMP_DIV), .SLOW_ZONE(SLOW_ZONE),
    .SLOW_DUTY(SLOW_DUTY), .BRAKE_CYCLES(BRAKE_CYCLES), .STALL_CYCLES(STALL_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .enc_step(enc_step), .enc_dir(enc_dir),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_target(cmd_target),
    .cmd_speed(cmd_speed), .abort(abort), .pos_clear(pos_clear), .fault_clr(fault_clr),
    .motor_en(motor_en), .motor_dir(motor_dir), .pwm_duty(pwm_duty), .position(position),
    .busy(busy), .done(done), .status(status), .fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit               is_fault;
    logic [1:0]       status;
    logic [POS_W-1:0] pos;
    bit               moved;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int total = 0;
  int bad = 0;

  logic [POS_W-1:0]  model_pos = '0;
  logic [POS_W-1:0]  cur_target = '0;
  logic [POS_W-1:0]  abort_pos = '0;
  logic [DUTY_W-1:0] cur_speed = '0;
  logic              exp_dir = 1'b0;
  bit enc_on = 1'b0;
  bit abort_armed = 1'b0;
  int clr_req = 0;
  int clr_seen = 0;
  int phase = 0;
  int k = 0;
  int last_k = 0;
  bit en_seen = 1'b0;
  bit fault_prev = 1'b0;

  task automatic checkOutput(input string name, input longint act, input longint expv, input int tol);
    longint diff;
    total++;
    diff = act - expv;
    if (diff < 0) diff = -diff;
    if (diff > longint'(tol)) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, expv);
    end
  endtask

  // Expected duty: linear ramp of one step per RAMP_DIV cycles, capped by the speed limit.
  function automatic int expDuty(input int kk);
    logic signed [POS_W-1:0] rs;
    int r, cap;
    rs = cur_target - model_pos;
    r = int'(rs);
    if (r < 0) r = -r;
    cap = int'(cur_speed);
    if (r <= SLOW_ZONE && cap > SLOW_DUTY) cap = SLOW_DUTY;
    return ((kk / RAMP_DIV) < cap) ? (kk / RAMP_DIV) : cap;
  endfunction

  // Encoder plant: one step every STEP_PERIOD cycles while driven; also raises abort
  // once the plant reaches the armed abort position.
  initial begin
    forever begin
      @(negedge clk);
      if (clr_req != clr_seen) begin
        clr_seen = clr_req;
        model_pos = '0;
        phase = 0;
      end
      abort = abort_armed && (model_pos == abort_pos);
      if (enc_on && motor_en) begin
        phase++;
        if (phase == STEP_PERIOD) begin
          phase = 0;
          enc_step = 1'b1;
          enc_dir = motor_dir;
          model_pos = motor_dir ? model_pos + POS_W'(1) : model_pos - POS_W'(1);
        end else begin
          enc_step = 1'b0;
        end
      end else begin
        enc_step = 1'b0;
        phase = 0;
      end
    end
  end

  // Monitor: pops the scoreboard on done / fault and checks duty against the model.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (done) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_done", 1, 0, 0);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("end_kind", 0, longint'(mon_e.is_fault), 0);
          checkOutput("done_status", longint'(status), longint'(mon_e.status), 0);
          checkOutput("done_position", longint'(position), longint'(mon_e.pos), 0);
          checkOutput("done_motor_en", longint'(motor_en), 0, 0);
          checkOutput("motor_used", longint'(en_seen), longint'(mon_e.moved), 0);
        end
        en_seen = 1'b0;
      end
      if (fault && !fault_prev) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_fault", 1, 0, 0);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("end_kind", 1, longint'(mon_e.is_fault), 0);
          checkOutput("fault_status", longint'(status), longint'(mon_e.status), 0);
          checkOutput("fault_motor_en", longint'(motor_en), 0, 0);
          checkOutput("fault_duty", longint'(pwm_duty), 0, 0);
          checkOutput("stall_latency", longint'(last_k), longint'(STALL_CYCLES - 1), 0);
        end
        en_seen = 1'b0;
      end
      fault_prev = fault;
      if (motor_en) begin
        if (!en_seen) checkOutput("motor_dir", longint'(motor_dir), longint'(exp_dir), 0);
        en_seen = 1'b1;
        if (enc_on && phase >= 3 && phase <= 6)
          checkOutput("pwm_duty", longint'(pwm_duty), longint'(expDuty(k)), 1);
        last_k = k;
        k++;
      end else begin
        k = 0;
      end
    end
  end

  task automatic applyStimulus(input logic [POS_W-1:0] target, input logic [DUTY_W-1:0] speed,
                               input bit stall, input bit use_abort, input logic [POS_W-1:0] ab_pos);
    exp_t e;
    logic signed [POS_W-1:0] ds;
    int w;
    w = 0;
    while (!cmd_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) checkOutput("ready_timeout", 0, 1, 0);
    ds = target - model_pos;
    e.moved = (ds != 0);
    e.is_fault = 1'b0;
    e.status = ST_REACHED;
    e.pos = target;
    if (!e.moved) begin
      e.pos = model_pos;
    end else if (stall) begin
      e.is_fault = 1'b1;
      e.status = ST_STALL;
      e.pos = model_pos;
    end else if (use_abort && ab_pos != target) begin
      e.status = ST_ABORT;
      e.pos = ab_pos;
    end
    exp_dir = (ds > 0);
    cur_target = target;
    cur_speed = speed;
    enc_on = !stall;
    abort_pos = ab_pos;
    abort_armed = use_abort;
    exp_q.push_back(e);
    cmd_valid = 1'b1;
    cmd_target = target;
    cmd_speed = speed;
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("cmd_ready_drop", longint'(cmd_ready), 0, 0);
  endtask

  task automatic waitMoveEnd(input int budget);
    int c;
    c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (exp_q.size() != 0) begin
      checkOutput("move_timeout", longint'(exp_q.size()), 0, 0);
      exp_q.delete();
    end
    abort_armed = 1'b0;
    @(negedge clk);
  endtask

  task automatic clearFault();
    cmd_valid = 1'b1;
    cmd_target = model_pos + POS_W'(5);
    repeat (4) @(negedge clk);
    checkOutput("fault_ignores_cmd", longint'(cmd_ready), 0, 0);
    checkOutput("fault_held", longint'(fault), 1, 0);
    checkOutput("fault_status_held", longint'(status), longint'(ST_STALL), 0);
    cmd_valid = 1'b0;
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    checkOutput("fault_cleared", longint'(fault), 0, 0);
    checkOutput("ready_after_clr", longint'(cmd_ready), 1, 0);
  endtask

  task automatic clearPosIdle();
    pos_clear = 1'b1;
    @(negedge clk);
    pos_clear = 1'b0;
    clr_req++;
    checkOutput("pos_clear_idle", longint'(position), 0, 0);
    @(negedge clk);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_position"}, longint'(position), 0, 0);
    checkOutput({tag, "_motor_en"}, longint'(motor_en), 0, 0);
    checkOutput({tag, "_motor_dir"}, longint'(motor_dir), 0, 0);
    checkOutput({tag, "_pwm_duty"}, longint'(pwm_duty), 0, 0);
    checkOutput({tag, "_cmd_ready"}, longint'(cmd_ready), 1, 0);
    checkOutput({tag, "_busy"}, longint'(busy), 0, 0);
    checkOutput({tag, "_done"}, longint'(done), 0, 0);
    checkOutput({tag, "_status"}, longint'(status), 0, 0);
    checkOutput({tag, "_fault"}, longint'(fault), 0, 0);
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: got timeout, want finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkResetValues("reset");
    rst = 1'b1;
    @(negedge clk);

    applyStimulus(POS_W'(500), 8'd200, 1'b0, 1'b0, '0);
    waitMoveEnd(500 * STEP_PERIOD + BRAKE_CYCLES + 500);

    clearPosIdle();
    applyStimulus(-POS_W'(100), 8'd120, 1'b0, 1'b0, '0);
    waitMoveEnd(100 * STEP_PERIOD + BRAKE_CYCLES + 500);
    checkOutput("wrap_position", longint'(position), longint'(24'hFFFF9C), 0);

    applyStimulus(model_pos, 8'd90, 1'b0, 1'b0, '0);
    waitMoveEnd(10);

    applyStimulus(model_pos + POS_W'(30), 8'd100, 1'b1, 1'b0, '0);
    waitMoveEnd(STALL_CYCLES + 100);
    clearFault();

    clearPosIdle();
    applyStimulus(POS_W'(500), 8'd150, 1'b0, 1'b1, POS_W'(200));
    waitMoveEnd(500 * STEP_PERIOD + BRAKE_CYCLES + 500);

    applyStimulus(model_pos + POS_W'(60), 8'd70, 1'b0, 1'b1, model_pos + POS_W'(60));
    waitMoveEnd(60 * STEP_PERIOD + BRAKE_CYCLES + 500);

    applyStimulus(model_pos + POS_W'(40), 8'd60, 1'b0, 1'b0, '0);
    repeat (100) @(negedge clk);
    pos_clear = 1'b1;
    @(negedge clk);
    pos_clear = 1'b0;
    waitMoveEnd(40 * STEP_PERIOD + BRAKE_CYCLES + 500);

    for (int i = 0; i < 8; i++) begin
      int d;
      int sp;
      bit st;
      bit ua;
      logic [POS_W-1:0] ap;
      d = int'($urandom_range(0, 300)) - 150;
      if ($urandom_range(0, 7) == 0) d = 0;
      sp = int'($urandom_range(0, 255));
      st = ($urandom_range(0, 5) == 0) && (d != 0);
      ua = ($urandom_range(0, 3) == 0) && (d != 0);
      ap = model_pos;
      if (d > 0) ap = model_pos + POS_W'($urandom_range(1, d));
      else if (d < 0) ap = model_pos - POS_W'($urandom_range(1, -d));
      applyStimulus(model_pos + POS_W'(d), DUTY_W'(sp), st, ua, ap);
      waitMoveEnd(((d < 0) ? -d : d) * STEP_PERIOD + BRAKE_CYCLES + STALL_CYCLES + 500);
      if (st) clearFault();
    end

    applyStimulus(model_pos + POS_W'(300), 8'd180, 1'b0, 1'b0, '0);
    repeat (600) @(negedge clk);
    exp_q.delete();
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkResetValues("async_reset");
    clr_req++;
    enc_on = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
